// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the scoreboarded register file and its users.
package regfile_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_DEPTH = 8;

  // Address width for a given register count; never less than one bit.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/regfile_sb_cell.sv
// One register word plus its scoreboard busy bit; a reservation wins over a writeback.
module regfile_sb_cell #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             set,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             busy
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q    <= '0;
      busy <= 1'b0;
    end else begin
      if (load) q <= d;
      if (set)       busy <= 1'b1;
      else if (load) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with one write port, two bypassed read ports and a per-register busy scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter bit ZERO_REG = 1'b1,
  parameter bit TRISTATE = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      we,
  input  logic [clog2(DEPTH)-1:0]   waddr,
  input  logic [WIDTH-1:0]          wdata,
  input  logic                      rsv,
  input  logic [clog2(DEPTH)-1:0]   rsv_addr,
  input  logic                      oeA,
  input  logic [clog2(DEPTH)-1:0]   raddrA,
  output wire logic [WIDTH-1:0]     DA,
  output logic                      busyA,
  input  logic                      oeB,
  input  logic [clog2(DEPTH)-1:0]   raddrB,
  output wire logic [WIDTH-1:0]     DB,
  output logic                      busyB
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] word [DEPTH];
  logic [DEPTH-1:0] busy;

  genvar gi;

  // Out-of-range addresses never match any cell, so they fall out of the decode.
  for (gi = 0; gi < DEPTH; gi++) begin : g_cell
    localparam bit HARDWIRED = ZERO_REG && (gi == 0);
    logic load;
    logic set;

    assign load = we  && (waddr    == AW'(gi)) && !HARDWIRED;
    assign set  = rsv && (rsv_addr == AW'(gi)) && !HARDWIRED;

    regfile_sb_cell #(.WIDTH(WIDTH)) u_cell (
      .clk   (clk),
      .reset (reset),
      .load  (load),
      .set   (set),
      .d     (wdata),
      .q     (word[gi]),
      .busy  (busy[gi])
    );
  end

  logic [AW-1:0]    raddr_p [2];
  logic [WIDTH-1:0] val_p   [2];
  logic             bsy_p   [2];

  assign raddr_p[0] = raddrA;
  assign raddr_p[1] = raddrB;

  for (gi = 0; gi < 2; gi++) begin : g_rport
    logic hit;

    always_comb begin
      val_p[gi] = '0;
      bsy_p[gi] = 1'b0;
      hit       = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        if (raddr_p[gi] == AW'(i)) begin
          val_p[gi] = word[i];
          bsy_p[gi] = busy[i];
          hit       = 1'b1;
        end
      end
      // A same-cycle writeback is forwarded and reads as ready.
      if (hit && we && (waddr == raddr_p[gi])) begin
        val_p[gi] = wdata;
        bsy_p[gi] = 1'b0;
      end
      if (ZERO_REG && (raddr_p[gi] == '0)) begin
        val_p[gi] = '0;
        bsy_p[gi] = 1'b0;
      end
    end
  end

  assign busyA = bsy_p[0];
  assign busyB = bsy_p[1];

  if (TRISTATE) begin : g_tri
    assign DA = oeA ? val_p[0] : {WIDTH{1'bz}};
    assign DB = oeB ? val_p[1] : {WIDTH{1'bz}};
  end else begin : g_zero
    assign DA = oeA ? val_p[0] : '0;
    assign DB = oeB ? val_p[1] : '0;
  end

endmodule
